// File: rtl/uart_rx_fifo_if.sv
// Receive-FIFO bus: UART writer side, consumer read side, error status and clear.
interface uart_rx_fifo_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4,
    parameter int CNT_W  = 8
);
    logic              wr_i;
    logic              wr_rdy_o;
    logic [DATA_W-1:0] wr_data_i;
    logic              line_err_i;
    logic              wr_err_i;
    logic              rd_i;
    logic              rd_rdy_o;
    logic [DATA_W-1:0] rd_data_o;
    logic [ADDR_W:0]   level_o;
    logic              err_clr_i;
    logic              line_err_o;
    logic              ovf_o;
    logic [CNT_W-1:0]  err_cnt_o;

    modport slave (
        input  wr_i, wr_data_i, line_err_i, wr_err_i, rd_i, err_clr_i,
        output wr_rdy_o, rd_rdy_o, rd_data_o, level_o, line_err_o, ovf_o, err_cnt_o
    );

    modport master (
        output wr_i, wr_data_i, line_err_i, wr_err_i, rd_i, err_clr_i,
        input  wr_rdy_o, rd_rdy_o, rd_data_o, level_o, line_err_o, ovf_o, err_cnt_o
    );
endinterface

// File: rtl/uart_rx_fifo.sv
// UART receive FIFO, first-word-fall-through (write visible next cycle); full drops writes and
// flags overflow, empty ignores reads. Sticky line/overflow flags plus a saturating error counter.
module uart_rx_fifo #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4,
    parameter int CNT_W  = 8
) (
    input  logic           clk_i,
    input  logic           rst_i,
    uart_rx_fifo_if.slave  bus
);
    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W:0]  DEPTH_L = (ADDR_W + 1)'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W:0]   wr_ptr;
    logic [ADDR_W:0]   rd_ptr;
    logic [ADDR_W:0]   level;
    logic              full;
    logic              empty;
    logic              wr_acc;
    logic              rd_acc;
    logic              ovf_evt;
    logic              err_evt;
    logic              line_err_q;
    logic              ovf_q;
    logic [CNT_W-1:0]  err_cnt_q;

    assign level   = wr_ptr - rd_ptr;
    assign full    = (level == DEPTH_L);
    assign empty   = (level == '0);
    assign wr_acc  = bus.wr_i && !full;
    assign rd_acc  = bus.rd_i && !empty;
    assign ovf_evt = (bus.wr_i && full) || bus.wr_err_i;
    assign err_evt = ovf_evt || bus.line_err_i;

    assign bus.wr_rdy_o   = !full;
    assign bus.rd_rdy_o   = !empty;
    assign bus.rd_data_o  = mem[rd_ptr[ADDR_W-1:0]];
    assign bus.level_o    = level;
    assign bus.line_err_o = line_err_q;
    assign bus.ovf_o      = ovf_q;
    assign bus.err_cnt_o  = err_cnt_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_acc) begin
            mem[wr_ptr[ADDR_W-1:0]] <= bus.wr_data_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
            if (rd_acc) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // A same-cycle error event beats the clear, so the counter restarts at 1.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            line_err_q <= 1'b0;
            ovf_q      <= 1'b0;
            err_cnt_q  <= '0;
        end else begin
            if (bus.line_err_i)     line_err_q <= 1'b1;
            else if (bus.err_clr_i) line_err_q <= 1'b0;

            if (ovf_evt)            ovf_q <= 1'b1;
            else if (bus.err_clr_i) ovf_q <= 1'b0;

            if (bus.err_clr_i)                      err_cnt_q <= err_evt ? CNT_W'(1) : '0;
            else if (err_evt && err_cnt_q != CNT_MAX) err_cnt_q <= err_cnt_q + 1'b1;
        end
    end
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: FWFT ordering, overflow, wrap, error flags/counter, async reset.
module tb_uart_rx_fifo;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;

    uart_rx_fifo_if #(.DATA_W(8), .ADDR_W(4), .CNT_W(8)) bus ();

    uart_rx_fifo #(.DATA_W(8), .ADDR_W(4), .CNT_W(8)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.wr_i = 0; bus.rd_i = 0; bus.line_err_i = 0; bus.wr_err_i = 0; bus.err_clr_i = 0;
    endtask

    initial begin
        bus.wr_data_i = '0;
        idle();
        #2;
        chk("rst_level", bus.level_o, 0);
        chk("rst_wr_rdy", bus.wr_rdy_o, 1);
        chk("rst_rd_rdy", bus.rd_rdy_o, 0);
        chk("rst_rd_data", bus.rd_data_o, 0);
        chk("rst_flags", {bus.line_err_o, bus.ovf_o}, 0);
        chk("rst_cnt", bus.err_cnt_o, 0);
        #10 rst = 1'b0;
        tick();

        // Three writes, then FWFT pops.
        bus.wr_i = 1; bus.wr_data_i = 8'h41; tick();
        chk("w1_level", bus.level_o, 1);
        chk("w1_rd_rdy", bus.rd_rdy_o, 1);
        chk("w1_head", bus.rd_data_o, 8'h41);
        bus.wr_data_i = 8'h42; tick();
        chk("w2_level", bus.level_o, 2);
        bus.wr_data_i = 8'h43; tick();
        chk("w3_level", bus.level_o, 3);
        bus.wr_i = 0; bus.rd_i = 1;
        for (int i = 0; i < 3; i++) begin
            chk("pop_data", bus.rd_data_o, 8'h41 + i);
            tick();
        end
        bus.rd_i = 0;
        chk("pop_rd_rdy", bus.rd_rdy_o, 0);
        chk("pop_level", bus.level_o, 0);

        // Fill to full, overflow, then overflow with a simultaneous read.
        bus.wr_i = 1;
        for (int i = 0; i < 16; i++) begin
            bus.wr_data_i = 8'(i); tick();
        end
        chk("full_wr_rdy", bus.wr_rdy_o, 0);
        chk("full_level", bus.level_o, 16);
        bus.wr_data_i = 8'hFF; tick();
        chk("ovf_flag", bus.ovf_o, 1);
        chk("ovf_cnt", bus.err_cnt_o, 1);
        chk("ovf_level", bus.level_o, 16);
        chk("ovf_head", bus.rd_data_o, 8'h00);
        bus.wr_data_i = 8'hEE; bus.rd_i = 1; tick();
        chk("ovf_rd_level", bus.level_o, 15);
        chk("ovf_rd_cnt", bus.err_cnt_o, 2);
        bus.wr_i = 0;
        for (int i = 1; i < 16; i++) begin
            chk("drain_data", bus.rd_data_o, i);
            tick();
        end
        bus.rd_i = 0;
        chk("drain_level", bus.level_o, 0);
        bus.err_clr_i = 1; tick(); bus.err_clr_i = 0;

        // Level 5 streaming across the pointer wrap.
        bus.wr_i = 1;
        for (int i = 0; i < 5; i++) begin
            bus.wr_data_i = 8'h10 + 8'(i); tick();
        end
        chk("lvl5", bus.level_o, 5);
        bus.rd_i = 1;
        for (int i = 0; i < 20; i++) begin
            bus.wr_data_i = 8'h15 + 8'(i);
            chk("stream_data", bus.rd_data_o, 8'h10 + i);
            tick();
            chk("stream_level", bus.level_o, 5);
        end
        bus.wr_i = 0;
        for (int i = 0; i < 5; i++) begin
            chk("stream_tail", bus.rd_data_o, 8'h24 + i);
            tick();
        end
        bus.rd_i = 0;
        chk("stream_empty", bus.level_o, 0);

        // Coincident line and dropped-byte errors count once; then saturation; then clear.
        bus.line_err_i = 1; bus.wr_err_i = 1; tick(); idle();
        chk("both_line", bus.line_err_o, 1);
        chk("both_ovf", bus.ovf_o, 1);
        chk("both_cnt", bus.err_cnt_o, 1);
        bus.line_err_i = 1;
        for (int i = 0; i < 300; i++) tick();
        bus.line_err_i = 0;
        chk("sat_cnt", bus.err_cnt_o, 255);
        tick();
        chk("sat_hold", bus.err_cnt_o, 255);
        bus.err_clr_i = 1; tick(); bus.err_clr_i = 0;
        chk("clr_all", {bus.line_err_o, bus.ovf_o, bus.err_cnt_o}, 0);

        // Clear loses to a coincident line error; read while empty is ignored.
        bus.err_clr_i = 1; bus.line_err_i = 1; tick(); idle();
        chk("clrwin_line", bus.line_err_o, 1);
        chk("clrwin_cnt", bus.err_cnt_o, 1);
        chk("clrwin_ovf", bus.ovf_o, 0);
        bus.rd_i = 1; tick(); bus.rd_i = 0;
        chk("rd_empty_level", bus.level_o, 0);
        chk("rd_empty_rdy", bus.rd_rdy_o, 0);
        chk("rd_empty_cnt", bus.err_cnt_o, 1);

        // Asynchronous reset at level 7 while a write is pending.
        bus.wr_i = 1;
        for (int i = 0; i < 7; i++) begin
            bus.wr_data_i = 8'h60 + 8'(i); tick();
        end
        chk("pre_rst_level", bus.level_o, 7);
        bus.wr_data_i = 8'h77;
        #2 rst = 1'b1;
        #1;
        chk("arst_level", bus.level_o, 0);
        chk("arst_rdy", {bus.wr_rdy_o, bus.rd_rdy_o}, 2'b10);
        chk("arst_rd_data", bus.rd_data_o, 0);
        chk("arst_flags", {bus.line_err_o, bus.ovf_o, bus.err_cnt_o}, 0);
        rst = 1'b0;
        bus.wr_data_i = 8'h55; tick(); bus.wr_i = 0;
        chk("post_rst_level", bus.level_o, 1);
        chk("post_rst_data", bus.rd_data_o, 8'h55);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
